// File: rtl/gardner_timing_nco.sv
// Gardner symbol-timing NCO: phase accumulator, symbol/mid strobes, clamped period correction.
// Optional lock detector is built when GARDNER_LOCK_DETECT_EN is defined.
module gardner_timing_nco #(
  parameter  int WIDTH      = 16,
  parameter  int OSR_LOG2   = 5,
  parameter  int FRAC       = 8,
  parameter  int CLAMP_LOG2 = 3,
  parameter  int LOCK_CNT   = 64,
  localparam int PW         = OSR_LOG2 + FRAC + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] I_in,
  input  logic signed [WIDTH-1:0] Q_in,
  input  logic signed [WIDTH-1:0] err,
  input  logic                    err_valid,
  input  logic [3:0]              gain_shift,
  input  logic [WIDTH-2:0]        lock_thr,
  output logic                    sym_valid,
  output logic signed [WIDTH-1:0] I_sym,
  output logic signed [WIDTH-1:0] Q_sym,
  output logic                    mid_valid,
  output logic signed [WIDTH-1:0] I_mid,
  output logic signed [WIDTH-1:0] Q_mid,
  output logic [PW-1:0]           period,
  output logic                    lock
);

  localparam logic [PW-1:0] P0   = PW'(1) << (OSR_LOG2 + FRAC);
  localparam logic [PW-1:0] STEP = PW'(1) << FRAC;
  localparam int            CW   = ((WIDTH > PW + 1) ? WIDTH : PW + 1) + 1;
  localparam logic signed [CW-1:0] LIM  = CW'(P0 >> CLAMP_LOG2);
  localparam logic signed [CW-1:0] NLIM = -LIM;

  typedef enum logic [1:0] {
    IDLE,
    FIRST_HALF,
    SECOND_HALF
  } state_t;

  state_t r_state;
  state_t w_state_d;

  logic [PW-1:0] r_acc;
  logic [PW-1:0] w_acc_nx;
  logic [PW-1:0] w_acc_d;
  logic          w_sym;
  logic          w_mid;

  logic signed [WIDTH-1:0] w_shr;
  logic signed [CW-1:0]    w_shr_x;
  logic signed [PW:0]      w_corr;
  logic signed [PW:0]      r_corr;
  logic [PW-1:0]           w_pnew;

  assign w_acc_nx = r_acc + STEP;

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_sym     = 1'b0;
    w_mid     = 1'b0;
    if (!en) begin
      w_state_d = IDLE;
      w_acc_d   = '0;
    end else if (r_state == IDLE) begin
      w_state_d = FIRST_HALF;
      w_acc_d   = '0;
    end else if (in_valid) begin
      w_acc_d = w_acc_nx;
      if (w_acc_nx >= period) begin
        w_sym     = 1'b1;
        w_acc_d   = w_acc_nx - period;
        w_state_d = FIRST_HALF;
      end else if (r_state == FIRST_HALF &&
                   w_acc_nx >= (period >> 1)) begin
        w_mid     = 1'b1;
        w_state_d = SECOND_HALF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
    end
  end

  // Shift in the error's own width, then widen so the clamp compare cannot wrap.
  assign w_shr   = err >>> gain_shift;
  assign w_shr_x = {{(CW-WIDTH){w_shr[WIDTH-1]}}, w_shr};

  always_comb begin
    w_corr = w_shr_x[PW:0];
    if (w_shr_x > LIM) begin
      w_corr = LIM[PW:0];
    end else if (w_shr_x < NLIM) begin
      w_corr = NLIM[PW:0];
    end
  end

  assign w_pnew = P0 + PW'(r_corr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid <= 1'b0;
      mid_valid <= 1'b0;
      I_sym     <= '0;
      Q_sym     <= '0;
      I_mid     <= '0;
      Q_mid     <= '0;
      period    <= P0;
      r_corr    <= '0;
    end else begin
      sym_valid <= w_sym;
      mid_valid <= w_mid;
      if (w_sym) begin
        I_sym  <= I_in;
        Q_sym  <= Q_in;
        period <= w_pnew;
      end
      if (w_mid) begin
        I_mid <= I_in;
        Q_mid <= Q_in;
      end
      if (err_valid) begin
        r_corr <= w_corr;
      end
    end
  end

`ifdef GARDNER_LOCK_DETECT_EN
  localparam int CNTW = $clog2(LOCK_CNT + 1);

  logic [CNTW-1:0]  r_lock_cnt;
  logic [WIDTH-1:0] r_abs_err;
  logic [WIDTH-1:0] w_abs_err;

  assign w_abs_err = err[WIDTH-1] ? ((~err) + 1'b1) : err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
      r_abs_err  <= '0;
    end else begin
      if (err_valid) begin
        r_abs_err <= w_abs_err;
      end
      if (!en || r_state == IDLE) begin
        r_lock_cnt <= '0;
      end else if (w_sym) begin
        if (r_abs_err <= {1'b0, lock_thr}) begin
          if (r_lock_cnt < CNTW'(LOCK_CNT)) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end else begin
          r_lock_cnt <= '0;
        end
      end
    end
  end

  assign lock = (r_lock_cnt >= CNTW'(LOCK_CNT));
`else
  logic w_unused_thr;
  assign w_unused_thr = ^lock_thr;
  assign lock         = 1'b0;
`endif

endmodule

// File: tb/tb_gardner_timing_nco.sv
// Randomized bench for gardner_timing_nco against a behavioural timing model.
// Lock expectations follow GARDNER_LOCK_DETECT_EN.
module tb_gardner_timing_nco;

  localparam int PW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic err_valid = 1'b0;
  logic signed [15:0] I_in = '0;
  logic signed [15:0] Q_in = '0;
  logic signed [15:0] err = '0;
  logic [3:0] gain_shift = '0;
  logic [14:0] lock_thr = '0;

  logic sym_valid;
  logic mid_valid;
  logic lock;
  logic signed [15:0] I_sym;
  logic signed [15:0] Q_sym;
  logic signed [15:0] I_mid;
  logic signed [15:0] Q_mid;
  logic [PW-1:0] period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gardner_timing_nco dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .I_in       (I_in),
    .Q_in       (Q_in),
    .err        (err),
    .err_valid  (err_valid),
    .gain_shift (gain_shift),
    .lock_thr   (lock_thr),
    .sym_valid  (sym_valid),
    .I_sym      (I_sym),
    .Q_sym      (Q_sym),
    .mid_valid  (mid_valid),
    .I_mid      (I_mid),
    .Q_mid      (Q_mid),
    .period     (period),
    .lock       (lock)
  );

  // Model: phase in integer units of 1/256 sample, period in the same units.
  bit m_run = 0;
  bit m_second = 0;
  int m_phase = 0;
  int m_P = 8192;
  int m_corr = 0;
  int m_abs = 0;
  int m_cnt = 0;
  int m_nsamp = 0;
  int m_gap = 0;
  int m_mid_at = 0;
  int m_clk = 0;
  int m_clkgap = 0;
  bit e_sym = 0;
  bit e_mid = 0;
  int e_Is = 0;
  int e_Qs = 0;
  int e_Im = 0;
  int e_Qm = 0;

  function automatic void chk(string n, logic signed [63:0] act,
                              logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", n, act, exp, $time);
    end
  endfunction

  function automatic int clampv(int e, int g);
    int s;
    s = e >>> g;
    if (s > 1024) s = 1024;
    if (s < -1024) s = -1024;
    return s;
  endfunction

  function automatic int lock_exp();
`ifdef GARDNER_LOCK_DETECT_EN
    return (m_cnt >= 64) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_run = 0; m_second = 0; m_phase = 0; m_P = 8192;
    m_corr = 0; m_abs = 0; m_cnt = 0; m_nsamp = 0; m_clk = 0;
    e_sym = 0; e_mid = 0; e_Is = 0; e_Qs = 0; e_Im = 0; e_Qm = 0;
  endfunction

  function automatic void model_step();
    int e;
    e_sym = 0;
    e_mid = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_clk++;
    if (!en) begin
      m_run = 0; m_phase = 0; m_cnt = 0;
    end else if (!m_run) begin
      m_run = 1; m_second = 0; m_phase = 0; m_nsamp = 0; m_clk = 0;
    end else if (in_valid) begin
      m_nsamp++;
      m_phase += 256;
      if (m_phase >= m_P) begin
        e_sym = 1;
        m_phase -= m_P;
        m_second = 0;
        m_P = 8192 + m_corr;
        if (m_abs <= int'(lock_thr)) m_cnt = (m_cnt < 64) ? m_cnt + 1 : 64;
        else m_cnt = 0;
        e_Is = I_in; e_Qs = Q_in;
        m_gap = m_nsamp; m_nsamp = 0;
        m_clkgap = m_clk; m_clk = 0;
      end else if (!m_second && m_phase >= m_P / 2) begin
        e_mid = 1;
        m_second = 1;
        e_Im = I_in; e_Qm = Q_in;
        m_mid_at = m_nsamp;
      end
    end
    if (err_valid) begin
      e = err;
      m_corr = clampv(e, int'(gain_shift));
      m_abs = (e < 0) ? -e : e;
    end
  endfunction

  always @(posedge clk) begin
    model_step();
    #1;
    chk("sym_valid", sym_valid, e_sym);
    chk("mid_valid", mid_valid, e_mid);
    chk("period", period, m_P);
    chk("lock", lock, lock_exp());
    chk("I_sym", I_sym, e_Is);
    chk("Q_sym", Q_sym, e_Qs);
    chk("I_mid", I_mid, e_Im);
    chk("Q_mid", Q_mid, e_Qm);
  end

  task automatic step();
    I_in = 16'($urandom);
    Q_in = 16'($urandom);
    @(posedge clk);
    #2;
    err_valid = 1'b0;
  endtask

  task automatic run_sym(string n, int maxc, bit alt);
    bit hit;
    hit = 0;
    for (int i = 0; i < maxc; i++) begin
      if (alt) in_valid = ~in_valid;
      step();
      if (e_sym) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=no_sym required=sym_within_%0d", n, maxc);
    end
  endtask

  task automatic pulse_err(int e, int g);
    err = 16'(e);
    gain_shift = 4'(g);
    err_valid = 1'b1;
    step();
  endtask

  task automatic reset_checks(string n);
    chk({n, "_sym"}, sym_valid, 0);
    chk({n, "_mid"}, mid_valid, 0);
    chk({n, "_period"}, period, 8192);
    chk({n, "_Isym"}, I_sym, 0);
    chk({n, "_Qmid"}, Q_mid, 0);
    chk({n, "_lock"}, lock, 0);
  endtask

  initial begin
    bit hit;
    #2 rst_n = 1'b0;
    #1 reset_checks("rst");
    repeat (3) step();
    rst_n = 1'b1;

    // Nominal timing
    en = 1'b1; in_valid = 1'b1; lock_thr = 15'd100;
    run_sym("nom1", 40, 0);
    chk("nom_first_gap", m_gap, 32);
    chk("nom_mid_at", m_mid_at, 16);
    chk("nom_period", period, 8192);
    run_sym("nom2", 40, 0);
    chk("nom_gap", m_gap, 32);

    // Positive / negative / clamped corrections
    pulse_err(2048, 3);
    run_sym("pos_a", 40, 0); chk("pos_period", period, 8448);
    run_sym("pos_b", 40, 0); chk("pos_gap", m_gap, 33);
    pulse_err(-2048, 3);
    run_sym("neg_a", 40, 0); chk("neg_period", period, 7936);
    run_sym("neg_b", 40, 0); chk("neg_gap", m_gap, 31);
    pulse_err(32767, 0);
    run_sym("cmax_a", 40, 0); chk("cmax_period", period, 9216);
    run_sym("cmax_b", 40, 0); chk("cmax_gap", m_gap, 36);
    pulse_err(-32768, 0);
    run_sym("cmin_a", 40, 0); chk("cmin_period", period, 7168);
    run_sym("cmin_b", 40, 0); chk("cmin_gap", m_gap, 28);
    pulse_err(0, 0);
    run_sym("zero_a", 40, 0); chk("zero_period", period, 8192);

    // Half-rate samples, error on the symbol cycle
    run_sym("alt_a", 80, 1);
    run_sym("alt_b", 80, 1);
    chk("alt_clkgap", m_clkgap, 64);
    chk("alt_gap", m_gap, 32);
    hit = 0;
    for (int i = 0; i < 80; i++) begin
      in_valid = ~in_valid;
      if (m_run && en && in_valid && (m_phase + 256 >= m_P)) begin
        hit = 1;
        break;
      end
      step();
    end
    chk("alt_predict_found", hit, 1);
    err = 16'sd2048; gain_shift = 4'd3; err_valid = 1'b1;
    step();
    chk("evsym_strobe", sym_valid, 1);
    chk("evsym_period_now", period, 8192);
    run_sym("evsym_a", 80, 1); chk("evsym_period_next", period, 8448);
    run_sym("evsym_b", 80, 1); chk("evsym_clkgap", m_clkgap, 66);
    in_valid = 1'b1;
    pulse_err(0, 0);
    run_sym("evsym_c", 80, 0);

    // Reset mid-symbol and enable toggle
    repeat (10) step();
    rst_n = 1'b0;
    #1 reset_checks("midrst");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    en = 1'b0;
    repeat (2) step();
    reset_checks("entog");
    en = 1'b1;
    run_sym("post_rst", 40, 0);
    chk("post_rst_gap", m_gap, 32);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 60) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 25) == 0) begin
        err = 16'($urandom);
        gain_shift = 4'($urandom_range(0, 7));
        err_valid = 1'b1;
      end
      lock_thr = 15'($urandom);
      step();
    end

    // Lock detection
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    en = 1'b1; in_valid = 1'b1; lock_thr = 15'd100;
    pulse_err(50, 15);
    for (int k = 0; k < 63; k++) run_sym("lock_run", 40, 0);
    chk("lock_before_64", lock, 0);
    run_sym("lock_64", 40, 0);
`ifdef GARDNER_LOCK_DETECT_EN
    chk("lock_at_64", lock, 1);
`else
    chk("lock_at_64", lock, 0);
`endif
    pulse_err(200, 15);
    run_sym("lock_drop", 40, 0);
    chk("lock_after_bad", lock, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gardner_timing_nco.md
GARDNER_TIMING_NCO -- requirements
Module: gardner_timing_nco

Interface
REQ-001 Parameter WIDTH, default 16: I/Q sample and error width.
REQ-002 Parameter OSR_LOG2, default 5: log2 of nominal samples per symbol (OSR = 2^OSR_LOG2).
REQ-003 Parameter FRAC, default 8: fractional bits of the phase accumulator; PW = OSR_LOG2+FRAC+2.
REQ-004 Parameter CLAMP_LOG2, default 3: correction limit L = (OSR<<FRAC)>>CLAMP_LOG2.
REQ-005 Parameter LOCK_CNT, default 64: consecutive in-tolerance symbols needed for lock.
REQ-006 clk  in  1  sample-rate clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 en  in  1  run enable; low forces IDLE.
REQ-009 in_valid  in  1  qualifies I_in/Q_in.
REQ-010 I_in, Q_in  in  WIDTH signed  oversampled samples.
REQ-011 err  in  WIDTH signed  negated timing error from detector; err_valid  in  1  qualifies err.
REQ-012 gain_shift  in  4  arithmetic right shift applied to err.
REQ-013 lock_thr  in  WIDTH-1 unsigned  lock tolerance on |err|.
REQ-014 sym_valid  out  1; I_sym, Q_sym  out  WIDTH signed  symbol-instant samples.
REQ-015 mid_valid  out  1; I_mid, Q_mid  out  WIDTH signed  mid-symbol samples.
REQ-016 period  out  PW unsigned  active period P; lock  out  1  timing lock.

Function
REQ-017 FSM states IDLE, FIRST_HALF, SECOND_HALF; IDLE->FIRST_HALF when en=1; any state->IDLE when en=0 (acc cleared, no strobes).
REQ-018 Per accepted sample (in_valid=1, not IDLE): acc_next = acc + 2^FRAC; only in_valid cycles advance acc or produce strobes.
REQ-019 If acc_next >= P: sym_valid pulses, acc <= acc_next - P, state -> FIRST_HALF; symbol crossing has priority over mid crossing.
REQ-020 Else if state FIRST_HALF and acc_next >= P>>1: mid_valid pulses, acc <= acc_next, state -> SECOND_HALF.
REQ-021 Strobes and their sample registers update one clk after the accepted sample; samples captured are that sample's I_in/Q_in; registers hold otherwise.
REQ-022 On err_valid: corr_pending <= clamp(err >>> gain_shift, -L, +L), signed, computed at PW+1 bits without overflow.
REQ-023 P <= (OSR<<FRAC) + corr_pending on each sym_valid cycle only; err_valid coinciding with a symbol crossing affects the following period, not the current one.
REQ-024 Multiple err_valid within one symbol: last value wins.
REQ-025 lock_cnt increments on each sym_valid if the latest latched |err| <= lock_thr, else clears; lock=1 while lock_cnt >= LOCK_CNT (saturating); cleared in IDLE.

Reset
REQ-026 rst_n=0 asynchronously: state IDLE, acc 0, corr_pending 0, P = OSR<<FRAC, sym_valid/mid_valid 0, I_sym/Q_sym/I_mid/Q_mid 0, lock 0, lock_cnt 0.
REQ-027 Reset mid-symbol discards partial phase; after release and en=1, first sym_valid occurs after exactly OSR accepted samples.

Configuration
REQ-028 Macro GARDNER_LOCK_DETECT_EN: defined -> REQ-025 lock logic built; undefined -> lock tied 0, lock_thr ignored, no lock_cnt register.

Verification (OSR_LOG2=5, FRAC=8, CLAMP_LOG2=3: P0=8192, step 256, L=1024)
REQ-029 en=1, in_valid every cycle, no err -> mid_valid on 16th sample, sym_valid every 32 samples, period=8192.
REQ-030 err=+2048, gain_shift=3, one pulse -> next period P=8448, symbols 33 samples apart; err=-2048 -> P=7936, 31 samples.
REQ-031 err=+32767, gain_shift=0 -> clamped P=9216, 36-sample symbols; err=-32768 -> P=7168, 28-sample symbols.
REQ-032 in_valid every 2nd cycle -> sym_valid every 64 clks, strobes never on in_valid=0 cycles; err_valid on sym_valid cycle -> applied one period later.
REQ-033 rst_n low mid-symbol, then en toggled 1->0->1 -> all outputs at reset values, next sym_valid after 32 samples.
REQ-034 GARDNER_LOCK_DETECT_EN defined, lock_thr=100, |err|=50 each symbol -> lock rises on 64th sym_valid; one |err|=200 -> lock falls next symbol; macro undefined -> lock stays 0.
